// File: rtl/screen_ctl.sv
// Screen selection controller: frame-synchronous button qualification and
// IDLE/SINGLE/MULTI/OVER screen state machine with registered screen selects.
module screen_ctl #(
  parameter int unsigned HOLD_FRAMES = 3,
  parameter int unsigned END_FRAMES  = 120
) (
  input  logic clk65MHz,
  input  logic rst,
  input  logic vblnk,
  input  logic btn_single,
  input  logic btn_multi,
  input  logic btn_back,
  input  logic game_over,
  output logic frame_start,
  output logic screen_idle,
  output logic screen_single,
  output logic screen_multi,
  output logic screen_over
);

  typedef enum logic [1:0] {IDLE, SINGLE, MULTI, OVER} state_t;

  state_t     state, nxt;
  logic       vblnk_d;
  logic [3:0] hold [3];
  logic [2:0] btn;
  logic [2:0] qual;
  logic       pending;
  logic [7:0] end_cnt;
  logic       mode, nxt_mode;
  logic       load_end;

  assign btn = {btn_back, btn_multi, btn_single};

  // Hold counters saturate at HOLD_FRAMES, so the one-frame match on
  // HOLD_FRAMES-1 doubles as the no-auto-repeat lock until a low sample.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      qual[i] = frame_start && btn[i] && (hold[i] == 4'(HOLD_FRAMES - 1));
    end
  end

  always_comb begin
    nxt      = state;
    nxt_mode = mode;
    load_end = 1'b0;
    if (frame_start) begin
      case (state)
        IDLE: begin
          if (qual[0]) begin
            nxt      = SINGLE;
            nxt_mode = 1'b0;
          end else if (qual[1]) begin
            nxt      = MULTI;
            nxt_mode = 1'b1;
          end
        end
        SINGLE, MULTI: begin
          if (qual[2]) begin
            nxt = IDLE;
          end else if (pending) begin
            nxt      = OVER;
            load_end = 1'b1;
          end
        end
        OVER: begin
          if (qual[2] || end_cnt <= 8'd1) nxt = IDLE;
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      state         <= IDLE;
      vblnk_d       <= 1'b0;
      frame_start   <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) hold[i] <= '0;
      pending       <= 1'b0;
      end_cnt       <= '0;
      mode          <= 1'b0;
      screen_idle   <= 1'b1;
      screen_single <= 1'b0;
      screen_multi  <= 1'b0;
      screen_over   <= 1'b0;
    end else begin
      vblnk_d     <= vblnk;
      frame_start <= vblnk & ~vblnk_d;

      // A pulse landing in a frame_start cycle is kept for the next frame.
      if (game_over)        pending <= 1'b1;
      else if (frame_start) pending <= 1'b0;

      if (frame_start) begin
        for (int unsigned i = 0; i < 3; i++) begin
          if (!btn[i])                            hold[i] <= '0;
          else if (hold[i] != 4'(HOLD_FRAMES))    hold[i] <= hold[i] + 4'd1;
        end
      end

      if (load_end)
        end_cnt <= 8'(END_FRAMES);
      else if (frame_start && state == OVER && end_cnt != '0)
        end_cnt <= end_cnt - 8'd1;

      state         <= nxt;
      mode          <= nxt_mode;
      screen_idle   <= (nxt == IDLE);
      screen_single <= (nxt == SINGLE) || (nxt == OVER && !nxt_mode);
      screen_multi  <= (nxt == MULTI)  || (nxt == OVER &&  nxt_mode);
      screen_over   <= (nxt == OVER);
    end
  end

endmodule

// File: tb/tb_screen_ctl.sv
// Bench for screen_ctl: directed scenarios then random frames against a
// frame-level reference model of the screen selection rules.
module tb_screen_ctl;

  localparam int H = 3;
  localparam int E = 4;

  logic clk65MHz = 1'b0;
  logic rst, vblnk, btn_single, btn_multi, btn_back, game_over;
  logic frame_start, screen_idle, screen_single, screen_multi, screen_over;

  int total = 0;
  int bad   = 0;

  // Reference model: consecutive-high run lengths, screen, pending, frames left.
  int  run_s, run_m, run_b;
  int  scr;      // 0 menu, 1 single, 2 multi, 3 game over
  bit  ov_multi;
  bit  pend;
  int  left;

  screen_ctl #(.HOLD_FRAMES(H), .END_FRAMES(E)) dut (
    .clk65MHz     (clk65MHz),
    .rst          (rst),
    .vblnk        (vblnk),
    .btn_single   (btn_single),
    .btn_multi    (btn_multi),
    .btn_back     (btn_back),
    .game_over    (game_over),
    .frame_start  (frame_start),
    .screen_idle  (screen_idle),
    .screen_single(screen_single),
    .screen_multi (screen_multi),
    .screen_over  (screen_over)
  );

  always #5 clk65MHz = ~clk65MHz;

  task automatic step();
    @(posedge clk65MHz);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".idle"},   screen_idle,   scr == 0);
    chk({tag, ".single"}, screen_single, scr == 1 || (scr == 3 && !ov_multi));
    chk({tag, ".multi"},  screen_multi,  scr == 2 || (scr == 3 && ov_multi));
    chk({tag, ".over"},   screen_over,   scr == 3);
  endtask

  task automatic model_reset();
    run_s = 0; run_m = 0; run_b = 0;
    scr = 0; ov_multi = 0; pend = 0; left = 0;
  endtask

  task automatic model_frame(input logic s, input logic m, input logic b);
    bit qs, qm, qb;
    run_s = s ? run_s + 1 : 0;
    run_m = m ? run_m + 1 : 0;
    run_b = b ? run_b + 1 : 0;
    qs = (run_s == H);
    qm = (run_m == H);
    qb = (run_b == H);
    if (scr == 0) begin
      if (qs)      begin scr = 1; ov_multi = 0; end
      else if (qm) begin scr = 2; ov_multi = 1; end
    end else if (scr == 1 || scr == 2) begin
      if (qb)        scr = 0;
      else if (pend) begin scr = 3; left = E; end
    end else begin
      if (qb || left == 1) scr = 0;
      else                 left = left - 1;
    end
    pend = 0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    step();
    model_reset();
    check_outs({tag, ".rst"});
    chk({tag, ".rst.fs"}, frame_start, 1'b0);
    rst = 1'b0;
  endtask

  task automatic frame(input string tag, input logic s, input logic m,
                       input logic b, input bit go);
    btn_single = s; btn_multi = m; btn_back = b;
    vblnk = 1'b0;
    step();
    step();
    if (go) begin
      game_over = 1'b1;
      step();
      game_over = 1'b0;
      pend = 1;
    end
    chk({tag, ".fs_low"}, frame_start, 1'b0);
    vblnk = 1'b1;
    step();
    chk({tag, ".fs_pulse"}, frame_start, 1'b1);
    check_outs({tag, ".pre"});
    model_frame(s, m, b);
    step();
    chk({tag, ".fs_clear"}, frame_start, 1'b0);
    check_outs(tag);
  endtask

  initial begin
    logic rs, rm, rb;
    rst = 1'b1; vblnk = 1'b0; game_over = 1'b0;
    btn_single = 1'b0; btn_multi = 1'b0; btn_back = 1'b0;
    model_reset();
    step();
    do_reset("init");

    // Single held three frames; held through game over and its timeout.
    frame("s1", 1, 0, 0, 0);
    frame("s2", 1, 0, 0, 0);
    chk("s2.not_early", screen_single, 1'b0);
    frame("s3", 1, 0, 0, 0);
    chk("s3.single", screen_single, 1'b1);
    frame("go_s", 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) frame("over_s", 1, 0, 0, 0);
    chk("over_s.done", screen_idle, 1'b1);
    frame("held", 1, 0, 0, 0);
    frame("held", 1, 0, 0, 0);
    frame("rel", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) frame("re_s", 1, 0, 0, 0);

    // Back and game_over resolving in the same frame.
    frame("bk1", 0, 0, 1, 0);
    frame("bk2", 0, 0, 1, 0);
    frame("bk3", 0, 0, 1, 1);
    chk("bk3.idle", screen_idle, 1'b1);

    // Both buttons together, then a short multi press.
    do_reset("r2");
    for (int i = 0; i < 3; i++) frame("both", 1, 1, 0, 0);
    chk("both.single", screen_single, 1'b1);
    do_reset("r3");
    frame("m_short", 0, 1, 0, 0);
    frame("m_short", 0, 1, 0, 0);
    frame("m_rel", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) frame("m", 0, 1, 0, 0);
    frame("go_m", 0, 0, 0, 1);
    chk("go_m.multi", screen_multi, 1'b1);
    for (int i = 0; i < 4; i++) frame("over_m", 0, 0, 0, 0);

    // Back cuts game over short.
    for (int i = 0; i < 3; i++) frame("m2", 0, 1, 0, 0);
    frame("go_m2", 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) frame("ov_bk", 0, 0, 1, 0);

    // Reset mid game over, then game_over while idle.
    for (int i = 0; i < 3; i++) frame("m3", 0, 1, 0, 0);
    frame("go_m3", 0, 0, 0, 1);
    vblnk = 1'b0;
    step();
    do_reset("r_over");
    frame("go_idle", 0, 0, 0, 1);

    // Button held through reset needs fresh frames.
    frame("pre_r", 1, 0, 0, 0);
    frame("pre_r", 1, 0, 0, 0);
    btn_single = 1'b1;
    do_reset("r_held");
    for (int i = 0; i < 3; i++) frame("post_r", 1, 0, 0, 0);

    // Random frames.
    rs = 0; rm = 0; rb = 0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) < 2) rs = ~rs;
      if ($urandom_range(0, 9) < 2) rm = ~rm;
      if ($urandom_range(0, 19) < 2) rb = ~rb;
      if ($urandom_range(0, 29) == 0) do_reset("rnd_rst");
      frame("rnd", rs, rm, rb, $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
